// File: rtl/spi_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_seq
//  Purpose  : Sequences one SPI character transfer through the spi_core
//             register port: divider, slave select, TX word, CTRL/GO, then
//             waits for the done interrupt and reads back the RX word.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_seq #(
   parameter int          SS_NB      = 8,
   parameter int          TIMEOUT    = 4096,
   parameter logic [31:0] CTRL_FLAGS = 32'h0000_3000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [31:0]      req_data_i,
   input  logic [6:0]       req_len_i,
   input  logic [SS_NB-1:0] req_ss_i,
   input  logic [15:0]      divider_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_data_o,
   output logic             resp_err_o,
   output logic             reg_we_o,
   output logic             reg_re_o,
   output logic [7:0]       reg_addr_o,
   output logic [31:0]      reg_wdata_o,
   output logic [3:0]       reg_be_o,
   input  logic [31:0]      reg_rdata_i,
   input  logic             reg_err_i,
   input  logic             spi_intr_i,
   output logic             busy_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [7:0]  ADDR_RXTX = 8'h00;
   localparam logic [7:0]  ADDR_CTRL = 8'h10;
   localparam logic [7:0]  ADDR_DIV  = 8'h14;
   localparam logic [7:0]  ADDR_SS   = 8'h18;
   localparam logic [31:0] CTRL_GO   = 32'h0000_0100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_DIV  = 3'd1,
      ST_WR_SS   = 3'd2,
      ST_WR_TX   = 3'd3,
      ST_WR_CTRL = 3'd4,
      ST_WAIT    = 3'd5,
      ST_RD_RX   = 3'd6,
      ST_RESP    = 3'd7
   } state_t;

   state_t             state_q;
   logic [31:0]        data_q;
   logic [6:0]         len_q;
   logic [SS_NB-1:0]   ss_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               resp_valid_q;
   logic               resp_err_q;
   logic [31:0]        resp_data_q;
   logic               reg_we_q;
   logic               reg_re_q;
   logic [7:0]         reg_addr_q;
   logic [31:0]        reg_wdata_q;

   logic               len_ok_d;
   logic [31:0]        len_mask_d;

   // Request legality and RX mask for the latched character length
   assign len_ok_d   = (req_len_i != 7'd0) && (req_len_i <= 7'd32);
   assign len_mask_d = (len_q >= 7'd32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << len_q) - 32'd1);

   // Sequencer: strobes and response are registered alongside the next state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         data_q       <= '0;
         len_q        <= '0;
         ss_q         <= '0;
         cnt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= '0;
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
      end else begin
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         if ((reg_we_q || reg_re_q) && reg_err_i) begin
            // Any register access error ends the transfer immediately
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (req_valid_i) begin
                     data_q <= req_data_i;
                     len_q  <= req_len_i;
                     ss_q   <= req_ss_i;
                     if (len_ok_d) begin
                        state_q     <= ST_WR_DIV;
                        reg_we_q    <= 1'b1;
                        reg_addr_q  <= ADDR_DIV;
                        reg_wdata_q <= {16'h0000, divider_i};
                     end else begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                     end
                  end
               end
               ST_WR_DIV: begin
                  state_q     <= ST_WR_SS;
                  reg_we_q    <= 1'b1;
                  reg_addr_q  <= ADDR_SS;
                  reg_wdata_q <= 32'(ss_q);
               end
               ST_WR_SS: begin
                  state_q     <= ST_WR_TX;
                  reg_we_q    <= 1'b1;
                  reg_addr_q  <= ADDR_RXTX;
                  reg_wdata_q <= data_q;
               end
               ST_WR_TX: begin
                  state_q     <= ST_WR_CTRL;
                  reg_we_q    <= 1'b1;
                  reg_addr_q  <= ADDR_CTRL;
                  reg_wdata_q <= CTRL_FLAGS | CTRL_GO | {25'h0, len_q};
               end
               ST_WR_CTRL: begin
                  state_q <= ST_WAIT;
                  cnt_q   <= '0;
               end
               ST_WAIT: begin
                  // Interrupt takes priority over a coincident timeout
                  if (spi_intr_i) begin
                     state_q    <= ST_RD_RX;
                     reg_re_q   <= 1'b1;
                     reg_addr_q <= ADDR_RXTX;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               ST_RD_RX: begin
                  state_q      <= ST_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_data_q  <= reg_rdata_i & len_mask_d;
               end
               ST_RESP: begin
                  if (resp_ready_i) begin
                     state_q      <= ST_IDLE;
                     resp_valid_q <= 1'b0;
                     resp_err_q   <= 1'b0;
                     resp_data_q  <= '0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_data_o  = resp_data_q;
   assign reg_we_o     = reg_we_q;
   assign reg_re_o     = reg_re_q;
   assign reg_addr_o   = reg_addr_q;
   assign reg_wdata_o  = reg_wdata_q;
   assign reg_be_o     = 4'hF;

endmodule
`default_nettype wire
